// File: rtl/multdiv_ctrl_if.sv
// Issue, datapath-control and writeback bundle between the execute
// stage and the iterative multiply/divide sequencer.
interface multdiv_ctrl_if;
  logic        issue_valid;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  rd_in;
  logic [31:0] operand_b;
  logic        flush;
  logic        dp_load;
  logic        dp_step;
  logic        dp_mode;
  logic [31:0] dp_result;
  logic        dp_ovf;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;

  modport master (
    output issue_valid, opcode, alu_op, rd_in, operand_b, flush,
    output dp_result, dp_ovf,
    input  dp_load, dp_step, dp_mode, stall, busy,
    input  wb_valid, wb_rd, wb_data, exc_valid
  );

  modport slave (
    input  issue_valid, opcode, alu_op, rd_in, operand_b, flush,
    input  dp_result, dp_ovf,
    output dp_load, dp_step, dp_mode, stall, busy,
    output wb_valid, wb_rd, wb_data, exc_valid
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative mul/div datapath: stalls the pipe,
// strobes load/step for STEPS cycles, then issues a single writeback.
module multdiv_ctrl #(
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input logic           clock,
  input logic           reset,
  multdiv_ctrl_if.slave m
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [4:0] RSTATUS = 5'd30;
  localparam logic [2:0] EXC_OVF = 3'd4;
  localparam logic [2:0] EXC_DZ  = 3'd5;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             mode_q, mode_nx;
  logic [4:0]       rd_q, rd_nx;
  logic [2:0]       exc_q, exc_nx;
  logic [2:0]       code;
  logic             is_mul, is_div, accept, last;

  assign is_mul = (m.opcode == 5'b00000) && (m.alu_op == 5'b00110);
  assign is_div = (m.opcode == 5'b00000) && (m.alu_op == 5'b00111);
  // reset gates accept so that stall cannot rise while held in reset
  assign accept = m.issue_valid && (is_mul || is_div) && !m.flush && !reset;
  assign last   = (cnt == CNT_W'(STEPS - 1));

  // overflow is only known once the datapath finishes, so fold it in here
  assign code = (exc_q != 3'd0) ? exc_q :
                (!mode_q && m.dp_ovf) ? EXC_OVF : 3'd0;

  // state, step counter and latched instruction fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      rd_q   <= 5'd0;
      exc_q  <= 3'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mode_q <= mode_nx;
      rd_q   <= rd_nx;
      exc_q  <= exc_nx;
    end
  end

  // next-state and strobe/writeback decode
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    mode_nx     = mode_q;
    rd_nx       = rd_q;
    exc_nx      = exc_q;
    m.dp_load   = 1'b0;
    m.dp_step   = 1'b0;
    m.dp_mode   = 1'b0;
    m.stall     = 1'b0;
    m.busy      = (state != IDLE);
    m.wb_valid  = 1'b0;
    m.exc_valid = 1'b0;
    m.wb_rd     = 5'd0;
    m.wb_data   = 32'd0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          m.stall = 1'b1;
          rd_nx   = m.rd_in;
          mode_nx = is_div;
          if (is_div && (m.operand_b == 32'd0)) begin
            exc_nx   = EXC_DZ;
            state_nx = DONE;
          end else begin
            exc_nx   = 3'd0;
            state_nx = LOAD;
          end
        end
      end
      LOAD: begin
        m.dp_load = 1'b1;
        m.dp_mode = mode_q;
        m.stall   = 1'b1;
        cnt_nx    = '0;
        state_nx  = RUN;
      end
      RUN: begin
        m.dp_step = 1'b1;
        m.dp_mode = mode_q;
        m.stall   = 1'b1;
        cnt_nx    = cnt + CNT_W'(1);
        if (last) state_nx = DONE;
      end
      DONE: begin
        m.dp_mode = mode_q;
        if (code != 3'd0) begin
          m.wb_valid  = 1'b1;
          m.exc_valid = 1'b1;
          m.wb_rd     = RSTATUS;
          m.wb_data   = {29'd0, code};
        end else if (rd_q != 5'd0) begin
          m.wb_valid = 1'b1;
          m.wb_rd    = rd_q;
          m.wb_data  = m.dp_result;
        end
        state_nx = IDLE;
        cnt_nx   = '0;
        mode_nx  = 1'b0;
        rd_nx    = 5'd0;
        exc_nx   = 3'd0;
      end
      default: state_nx = IDLE;
    endcase
    // flush aborts from any state and kills this cycle's strobes
    if (m.flush) begin
      state_nx    = IDLE;
      cnt_nx      = '0;
      mode_nx     = 1'b0;
      rd_nx       = 5'd0;
      exc_nx      = 3'd0;
      m.dp_load   = 1'b0;
      m.dp_step   = 1'b0;
      m.wb_valid  = 1'b0;
      m.exc_valid = 1'b0;
      m.wb_rd     = 5'd0;
      m.wb_data   = 32'd0;
    end
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: inputs change on the falling edge,
// outputs are sampled 1ns later, state advances on the rising edge.
module tb_multdiv_ctrl;
  logic clock;
  logic reset;
  int   vectors;
  int   errs;

  multdiv_ctrl_if m ();

  multdiv_ctrl #(.STEPS(32), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .m    (m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_inst(input logic v, input logic [4:0] op,
                          input logic [4:0] fn, input logic [4:0] rd,
                          input logic [31:0] b);
    m.issue_valid = v;
    m.opcode      = op;
    m.alu_op      = fn;
    m.rd_in       = rd;
    m.operand_b   = b;
  endtask

  // Measures one operation starting in its accept cycle (already sampled).
  task automatic watch(output int lat, output int nstall,
                       output int nload, output int nstep,
                       output int nmode, output logic wv,
                       output logic [4:0] wrd, output logic [31:0] wd,
                       output logic ev, output logic found);
    lat = -1; nstall = 0; nload = 0; nstep = 0; nmode = 0;
    wv = 0; wrd = 0; wd = 0; ev = 0; found = 0;
    for (int c = 0; c < 45 && !found; c++) begin
      if (c > 0) begin @(negedge clock); #1; end
      nstall += int'(m.stall);
      nload  += int'(m.dp_load);
      nstep  += int'(m.dp_step);
      nmode  += int'(m.dp_step && m.dp_mode);
      if (m.busy && !m.stall) begin
        found = 1; lat = c;
        wv = m.wb_valid; wrd = m.wb_rd; wd = m.wb_data; ev = m.exc_valid;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    m.flush = 0; m.dp_result = 32'h1234_5678; m.dp_ovf = 1;
    set_inst(1, 5'd0, 5'd6, 5'd5, 32'd3);
    @(negedge clock); #1;
    vectors++;
    if ({m.stall, m.busy, m.dp_load, m.dp_step, m.dp_mode, m.wb_valid,
         m.exc_valid, m.wb_rd, m.wb_data} !== 44'd0) begin
      errs++;
      $display("FAIL reset_outs: got stall=%b busy=%b load=%b step=%b wbv=%b exp all 0",
               m.stall, m.busy, m.dp_load, m.dp_step, m.wb_valid);
    end
    @(negedge clock);
    set_inst(0, 5'd0, 5'd0, 5'd0, 32'd0);
    m.dp_ovf = 0;
    reset = 1'b0;
    #1;
    vectors++;
    if (m.busy !== 1'b0 || m.stall !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: busy=%b stall=%b exp 0 0", m.busy, m.stall);
    end
  endtask

  task automatic test_mul;
    int lat, ns, nl, nst, nm;
    logic wv, ev, f;
    logic [4:0] wrd;
    logic [31:0] wd;
    @(negedge clock);
    m.dp_result = 32'h0000_0F00; m.dp_ovf = 0;
    set_inst(1, 5'd0, 5'd6, 5'd5, 32'd3);
    #1;
    vectors++;
    if (m.stall !== 1'b1) begin
      errs++; $display("FAIL mul_accept_stall: got %b exp 1", m.stall);
    end
    watch(lat, ns, nl, nst, nm, wv, wrd, wd, ev, f);
    vectors++;
    if (!f || lat != 34 || ns != 34 || nl != 1 || nst != 32 || nm != 0) begin
      errs++;
      $display("FAIL mul_seq: got lat=%0d stall=%0d load=%0d step=%0d mode=%0d exp 34 34 1 32 0",
               lat, ns, nl, nst, nm);
    end
    vectors++;
    if ({wv, wrd, wd, ev} !== {1'b1, 5'd5, 32'h0000_0F00, 1'b0}) begin
      errs++;
      $display("FAIL mul_wb: got v=%b rd=%0d data=%h exc=%b exp 1 5 00000f00 0",
               wv, wrd, wd, ev);
    end
    @(negedge clock);
    m.issue_valid = 0;
    #1;
    vectors++;
    if (m.busy !== 1'b0) begin
      errs++; $display("FAIL mul_no_reaccept: busy=%b exp 0", m.busy);
    end
  endtask

  task automatic test_div0;
    int lat, ns, nl, nst, nm;
    logic wv, ev, f;
    logic [4:0] wrd;
    logic [31:0] wd;
    @(negedge clock);
    m.dp_result = 32'hAAAA_5555;
    set_inst(1, 5'd0, 5'd7, 5'd7, 32'd0);
    #1;
    watch(lat, ns, nl, nst, nm, wv, wrd, wd, ev, f);
    vectors++;
    if (!f || lat != 1 || ns != 1 || nl != 0 || nst != 0) begin
      errs++;
      $display("FAIL div0_seq: got lat=%0d stall=%0d load=%0d step=%0d exp 1 1 0 0",
               lat, ns, nl, nst);
    end
    vectors++;
    if ({wv, wrd, wd, ev} !== {1'b1, 5'd30, 32'd5, 1'b1}) begin
      errs++;
      $display("FAIL div0_wb: got v=%b rd=%0d data=%h exc=%b exp 1 30 5 1",
               wv, wrd, wd, ev);
    end
    @(negedge clock);
    m.issue_valid = 0;
  endtask

  task automatic test_mul_ovf;
    int lat, ns, nl, nst, nm;
    logic wv, ev, f;
    logic [4:0] wrd;
    logic [31:0] wd;
    @(negedge clock);
    m.dp_result = 32'hDEAD_BEEF; m.dp_ovf = 1;
    set_inst(1, 5'd0, 5'd6, 5'd12, 32'd9);
    #1;
    watch(lat, ns, nl, nst, nm, wv, wrd, wd, ev, f);
    vectors++;
    if (!f || lat != 34 || nst != 32 ||
        {wv, wrd, wd, ev} !== {1'b1, 5'd30, 32'd4, 1'b1}) begin
      errs++;
      $display("FAIL mul_ovf_wb: got lat=%0d v=%b rd=%0d data=%h exc=%b exp 34 1 30 4 1",
               lat, wv, wrd, wd, ev);
    end
    @(negedge clock);
    m.issue_valid = 0; m.dp_ovf = 0;
  endtask

  task automatic test_div_rd0;
    int lat, ns, nl, nst, nm;
    logic wv, ev, f;
    logic [4:0] wrd;
    logic [31:0] wd;
    @(negedge clock);
    m.dp_result = 32'h0000_0042; m.dp_ovf = 1;
    set_inst(1, 5'd0, 5'd7, 5'd0, 32'd3);
    #1;
    watch(lat, ns, nl, nst, nm, wv, wrd, wd, ev, f);
    vectors++;
    if (!f || lat != 34 || ns != 34 || nl != 1 || nst != 32 || nm != 32) begin
      errs++;
      $display("FAIL div_rd0_seq: got lat=%0d stall=%0d load=%0d step=%0d mode=%0d exp 34 34 1 32 32",
               lat, ns, nl, nst, nm);
    end
    vectors++;
    if (wv !== 1'b0 || ev !== 1'b0) begin
      errs++; $display("FAIL div_rd0_wb: got v=%b exc=%b exp 0 0", wv, ev);
    end
    @(negedge clock);
    m.issue_valid = 0; m.dp_ovf = 0;
  endtask

  task automatic test_ignored;
    logic [14:0] tbl [3];
    tbl[0] = {1'b0, 5'd0, 5'd5, 4'd0};
    tbl[1] = {1'b0, 5'd2, 5'd6, 4'd0};
    tbl[2] = {1'b1, 5'd0, 5'd6, 4'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      set_inst(1, tbl[i][13:9], tbl[i][8:4], 5'd4, 32'd1);
      m.flush = tbl[i][14];
      #1;
      vectors++;
      if (m.stall !== 1'b0) begin
        errs++; $display("FAIL ignored_stall_%0d: got %b exp 0", i, m.stall);
      end
      @(negedge clock);
      m.issue_valid = 0; m.flush = 0;
      #1;
      vectors++;
      if (m.busy !== 1'b0) begin
        errs++; $display("FAIL ignored_busy_%0d: got %b exp 0", i, m.busy);
      end
    end
  endtask

  task automatic test_flush;
    int nwb;
    logic step_pre;
    @(negedge clock);
    set_inst(1, 5'd0, 5'd6, 5'd9, 32'd2);
    #1;
    for (int c = 1; c <= 10; c++) begin @(negedge clock); #1; end
    step_pre = m.dp_step;
    @(negedge clock);
    m.flush = 1; m.issue_valid = 0;
    #1;
    vectors++;
    if (step_pre !== 1'b1 || m.dp_step !== 1'b0 || m.wb_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_step: got pre=%b now=%b wbv=%b exp 1 0 0",
               step_pre, m.dp_step, m.wb_valid);
    end
    @(negedge clock);
    m.flush = 0;
    #1;
    vectors++;
    if (m.busy !== 1'b0) begin
      errs++; $display("FAIL flush_busy: got %b exp 0", m.busy);
    end
    nwb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock); #1;
      nwb += int'(m.wb_valid);
    end
    vectors++;
    if (nwb != 0) begin
      errs++; $display("FAIL flush_no_wb: got %0d writebacks exp 0", nwb);
    end
  endtask

  task automatic test_async_reset;
    int nwb;
    @(negedge clock);
    set_inst(1, 5'd0, 5'd6, 5'd6, 32'd2);
    for (int c = 0; c < 6; c++) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({m.stall, m.busy, m.dp_load, m.dp_step, m.dp_mode, m.wb_valid,
         m.exc_valid, m.wb_rd, m.wb_data} !== 44'd0) begin
      errs++;
      $display("FAIL async_reset_outs: stall=%b busy=%b step=%b mode=%b exp all 0",
               m.stall, m.busy, m.dp_step, m.dp_mode);
    end
    @(negedge clock);
    m.issue_valid = 0;
    reset = 1'b0;
    nwb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock); #1;
      nwb += int'(m.wb_valid) + int'(m.busy);
    end
    vectors++;
    if (nwb != 0) begin
      errs++; $display("FAIL async_reset_quiet: got %0d wb/busy cycles exp 0", nwb);
    end
  endtask

  task automatic test_back_to_back;
    int lat, ns, nl, nst, nm;
    logic wv, ev, f;
    logic [4:0] wrd;
    logic [31:0] wd;
    @(negedge clock);
    m.dp_result = 32'h0000_0111; m.dp_ovf = 0;
    set_inst(1, 5'd0, 5'd6, 5'd3, 32'd5);
    #1;
    watch(lat, ns, nl, nst, nm, wv, wrd, wd, ev, f);
    vectors++;
    if (!f || lat != 34 || {wv, wrd, wd, ev} !== {1'b1, 5'd3, 32'h111, 1'b0}) begin
      errs++;
      $display("FAIL b2b_first: got lat=%0d v=%b rd=%0d data=%h exp 34 1 3 00000111",
               lat, wv, wrd, wd);
    end
    @(negedge clock);
    m.dp_result = 32'h0000_0222;
    set_inst(1, 5'd0, 5'd7, 5'd4, 32'd9);
    #1;
    vectors++;
    if (m.stall !== 1'b1) begin
      errs++; $display("FAIL b2b_accept: stall=%b exp 1", m.stall);
    end
    watch(lat, ns, nl, nst, nm, wv, wrd, wd, ev, f);
    vectors++;
    if (!f || lat != 34 || nm != 32 ||
        {wv, wrd, wd, ev} !== {1'b1, 5'd4, 32'h222, 1'b0}) begin
      errs++;
      $display("FAIL b2b_second: got lat=%0d mode=%0d v=%b rd=%0d data=%h exp 34 32 1 4 00000222",
               lat, nm, wv, wrd, wd);
    end
    @(negedge clock);
    m.issue_valid = 0;
  endtask

  initial begin
    vectors = 0;
    errs = 0;
    test_reset();
    test_mul();
    test_div0();
    test_mul_ovf();
    test_div_rd0();
    test_ignored();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer for the shared iterative multiply/divide datapath in the execute stage.
- Accepts mul/div from decode, stalls the pipeline, drives load/step strobes for a fixed step count, then issues one writeback.
- Writeback goes to rd, or to $r30 (rstatus) with an exception code on multiply overflow or divide-by-zero.

Parameters:
- STEPS, 32, iterative steps per operation (>=2)
- CNT_W, 6, step-counter width; must hold STEPS

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  execute-stage instruction valid
- opcode  input  5  instruction opcode
- alu_op  input  5  R-type function field
- rd_in  input  5  destination register
- operand_b  input  32  divisor/multiplier value, used for the zero check
- flush  input  1  abort in-flight operation
- dp_load  output  1  load operands into the datapath
- dp_step  output  1  advance the datapath one iteration
- dp_mode  output  1  0 = multiply, 1 = divide
- dp_result  input  32  datapath result, stable after the final step
- dp_ovf  input  1  datapath multiply-overflow flag, valid with dp_result
- stall  output  1  freeze PC/F/D/X
- busy  output  1  state != IDLE
- wb_valid  output  1  register write strobe
- wb_rd  output  5  write target
- wb_data  output  32  write data
- exc_valid  output  1  exception writeback this cycle

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous and active-high.
  - While reset is high, state = IDLE, counter = 0, and latched mode/rd/exception = 0.
  - All outputs are 0 during reset.
- Decode:
  - mul = (opcode == 00000) and (alu_op == 00110).
  - div = (opcode == 00000) and (alu_op == 00111).
  - Any other instruction is ignored; stall stays 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - accept = issue_valid & (mul|div) & ~flush.
  - stall = accept (combinational, same cycle).
  - On accept, latch rd_in and dp_mode.
  - If div with operand_b == 0: latch exception code 5, go to DONE (dp_load and dp_step never assert).
  - Otherwise go to LOAD.
- LOAD: dp_load = 1, stall = 1, counter <= 0, go to RUN.
- RUN:
  - dp_step = 1, stall = 1, counter increments each cycle.
  - When counter == STEPS-1, go to DONE. dp_step is therefore high for exactly STEPS cycles.
- DONE (exactly one cycle, stall = 0, then IDLE):
  - Mul with dp_ovf = 1: latch exception code 4 in that cycle.
  - Exception pending: wb_valid = 1, exc_valid = 1, wb_rd = 30, wb_data = code (4 = mul overflow, 5 = div by zero).
  - No exception, rd != 0: wb_valid = 1, wb_rd = rd, wb_data = dp_result.
  - No exception, rd == 0: wb_valid = 0 (no write to $r0).
- Outside DONE: wb_valid = exc_valid = 0, and wb_rd/wb_data = 0.
- Latency, accept cycle to wb_valid:
  - Normal: STEPS+2 cycles (34 at default).
  - Divide-by-zero: 1 cycle.
- Issue while busy: ignored. Pipeline is stalled, so the same instruction is re-presented but not re-accepted.
- The instruction presented in DONE is not accepted that cycle. The pipeline advances on the DONE edge, so the next instruction is examined in the following IDLE cycle.
- flush:
  - Any state: next state is IDLE, counter cleared, no writeback.
  - Strobes (dp_load, dp_step, wb_valid) are combinationally forced to 0 in the flush cycle.
  - Flush with issue in IDLE: not accepted.
- Async reset mid-RUN: returns to IDLE immediately, no writeback.
- dp_mode holds its latched value from LOAD through DONE; it is 0 in IDLE.

Test Plan:
- mul, rd = 5, dp_result = 0x00000F00, dp_ovf = 0:
  - stall high for 34 cycles (accept through last RUN).
  - dp_load for 1 cycle, dp_step for exactly 32 cycles.
  - Next cycle: wb_valid = 1, wb_rd = 5, wb_data = 0x00000F00, exc_valid = 0, stall = 0.
- div, operand_b = 0, rd = 7:
  - One cycle after accept: wb_valid = 1, wb_rd = 30, wb_data = 5, exc_valid = 1.
  - dp_load and dp_step never assert; total stall = 1 cycle.
- mul, dp_ovf = 1 in DONE: wb_rd = 30, wb_data = 4, exc_valid = 1; rd is not written.
- div, rd = 0, operand_b = 3: full 34-cycle sequence with wb_valid = 0 in DONE.
- Flush at the 10th RUN cycle: dp_step drops the same cycle, busy = 0 next cycle, and no wb_valid within the next 40 cycles.
- Async reset asserted mid-RUN, and back-to-back mul/div with no gap:
  - Reset: all outputs 0 immediately.
  - Back-to-back: second op accepted the cycle after DONE; both writebacks are correct and in order.
